pll_phase_ctrl: RTL and testbench

Dynamic phase-shift and lock supervisor for the MAX 10 `altpll` primitive. It sits beside the PLL instance and drives the PLL's `phasecounterselect`, `phasestep`, `phaseupdown` and `areset` pins. It accepts multi-step phase-shift requests for any of `NCLK` output counters, sequences the `phasestep`/`phasedone` handshake one step at a time, and recovers from loss of lock by pulsing `areset` and waiting for relock. `i_clk` must be the clock that also drives the PLL's `scanclk`.

---
 rtl/pll_phase_ctrl_if.sv | 15 +
 rtl/pll_phase_ctrl.sv | 135 +++++++++++++
 tb/tb_pll_phase_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_phase_ctrl_if.sv
// Request-side bus of the PLL phase controller: step request in, status pulses out.
interface pll_phase_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             i_req;
    logic [2:0]       i_sel;
    logic             i_updn;
    logic [CNT_W-1:0] i_nsteps;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    modport master (output i_req, i_sel, i_updn, i_nsteps, input o_busy, o_done, o_err);
    modport slave  (input i_req, i_sel, i_updn, i_nsteps, output o_busy, o_done, o_err);
endinterface

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer and lock supervisor for an altpll instance.
// Runs on the PLL scanclk; every output is registered from the next state.
module pll_phase_ctrl #(
    parameter int NCLK         = 5,
    parameter int CNT_W        = 8,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int PD_TIMEOUT   = 64,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    pll_phase_ctrl_if.slave       bus,
    output logic                  o_locked,
    output logic [3:0]            o_phasecounterselect,
    output logic                  o_phasestep,
    output logic                  o_phaseupdown,
    output logic                  o_areset,
    input  logic                  i_phasedone,
    input  logic                  i_locked
);
    localparam int TMAX = (LOCK_TIMEOUT > PD_TIMEOUT) ?
                          ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES) :
                          ((PD_TIMEOUT > RST_CYCLES) ? PD_TIMEOUT : RST_CYCLES);
    localparam int TW = $clog2(TMAX + GAP_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, STEP, WAIT_LO, WAIT_HI, GAP, RESET, RELOCK} state_t;

    state_t           state, next;
    logic [TW-1:0]    tmr, tmr_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [2:0]       sel_q, sel_nx;
    logic             dir_q, dir_nx;
    logic             done_nx, err_nx, lost, active;
    logic             lock_s1, lock_s;
    logic             busy_q, done_q, err_q;

    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
    assign bus.o_err  = err_q;

    always_comb begin
        next    = state;
        cnt_nx  = cnt_q;
        sel_nx  = sel_q;
        dir_nx  = dir_q;
        done_nx = 1'b0;
        err_nx  = 1'b0;
        lost    = (state != RESET) && (state != RELOCK) && !lock_s;
        case (state)
            IDLE: if (bus.i_req) begin
                if (int'(bus.i_sel) >= NCLK) err_nx = 1'b1;
                else if (bus.i_nsteps == '0) done_nx = 1'b1;
                else begin
                    sel_nx = bus.i_sel;
                    dir_nx = bus.i_updn;
                    cnt_nx = bus.i_nsteps;
                    next   = STEP;
                end
            end
            STEP: if (tmr == TW'(1)) next = WAIT_LO;
            WAIT_LO: begin
                if (!i_phasedone) next = WAIT_HI;
                else if (tmr == TW'(PD_TIMEOUT - 1)) begin
                    err_nx = 1'b1;
                    next   = RESET;
                end
            end
            WAIT_HI: begin
                if (i_phasedone) begin
                    cnt_nx = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        done_nx = 1'b1;
                        next    = IDLE;
                    end else next = GAP;
                end else if (tmr == TW'(PD_TIMEOUT - 1)) begin
                    err_nx = 1'b1;
                    next   = RESET;
                end
            end
            GAP:    if (tmr == TW'(GAP_CYCLES - 1)) next = STEP;
            RESET:  if (tmr == TW'(RST_CYCLES - 1)) next = RELOCK;
            RELOCK: begin
                if (lock_s) next = IDLE;
                else if (tmr == TW'(LOCK_TIMEOUT - 1)) next = RESET;
            end
            default: next = RELOCK;
        endcase
        // Lock loss overrides any completion or request outcome this cycle.
        if (lost) begin
            next    = RESET;
            done_nx = 1'b0;
            err_nx  = 1'b1;
            cnt_nx  = '0;
        end
        tmr_nx = (next != state) ? '0 : tmr + TW'(1);
        active = (next == STEP) || (next == WAIT_LO) || (next == WAIT_HI) || (next == GAP);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state                <= RELOCK;
            tmr                  <= '0;
            cnt_q                <= '0;
            sel_q                <= '0;
            dir_q                <= 1'b0;
            lock_s1              <= 1'b0;
            lock_s               <= 1'b0;
            busy_q               <= 1'b1;
            done_q               <= 1'b0;
            err_q                <= 1'b0;
            o_locked             <= 1'b0;
            o_phasecounterselect <= '0;
            o_phasestep          <= 1'b0;
            o_phaseupdown        <= 1'b0;
            o_areset             <= 1'b0;
        end else begin
            state                <= next;
            tmr                  <= tmr_nx;
            cnt_q                <= cnt_nx;
            sel_q                <= sel_nx;
            dir_q                <= dir_nx;
            lock_s1              <= i_locked;
            lock_s               <= lock_s1;
            busy_q               <= (next != IDLE);
            done_q               <= done_nx;
            err_q                <= err_nx;
            o_locked             <= lock_s && (next != RESET) && (next != RELOCK);
            o_phasecounterselect <= active ? (4'(sel_nx) + 4'd2) : 4'd0;
            o_phasestep          <= (next == STEP);
            o_phaseupdown        <= active && dir_nx;
            o_areset             <= (next == RESET);
        end
    end
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with a small behavioural PLL phasedone model.
module tb_pll_phase_ctrl;
    localparam int NCLK = 5, CNT_W = 8, RST_CYCLES = 8, LOCK_TIMEOUT = 200;
    localparam int PD_TIMEOUT = 16, GAP_CYCLES = 2;

    logic clk = 1'b0, rst_n, i_locked, phasedone = 1'b1;
    logic o_locked, o_phasestep, o_phaseupdown, o_areset;
    logic [3:0] o_pcs;
    logic pd_stuck;
    logic [3:0] exp_pcs;
    logic exp_updn;

    pll_phase_ctrl_if #(.CNT_W(CNT_W)) bus();

    pll_phase_ctrl #(.NCLK(NCLK), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .PD_TIMEOUT(PD_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus), .o_locked(o_locked),
        .o_phasecounterselect(o_pcs), .o_phasestep(o_phasestep), .o_phaseupdown(o_phaseupdown),
        .o_areset(o_areset), .i_phasedone(phasedone), .i_locked(i_locked));

    always #5 clk = ~clk;

    // PLL model: phasedone drops 2 cycles after a step starts, rises 3 cycles later.
    logic ps_q = 1'b0;
    int   mcnt = 0;
    always @(posedge clk) begin
        ps_q <= o_phasestep;
        if (o_phasestep && !ps_q && !pd_stuck) mcnt <= 1;
        else if (mcnt != 0) begin
            if (mcnt == 2) phasedone <= 1'b0;
            if (mcnt == 5) begin
                phasedone <= 1'b1;
                mcnt <= 0;
            end else mcnt <= mcnt + 1;
        end
    end

    // Cumulative pulse monitors, sampled on the falling edge.
    int n_ps = 0, n_ps_badlen = 0, n_ps_badsel = 0, ps_run = 0;
    int n_done = 0, n_err = 0, n_both = 0, n_ars = 0, ars_run = 0, ars_len_last = 0;
    always @(negedge clk) begin
        if (o_phasestep) begin
            if (ps_run == 0) n_ps <= n_ps + 1;
            ps_run <= ps_run + 1;
            if (o_pcs != exp_pcs || o_phaseupdown != exp_updn) n_ps_badsel <= n_ps_badsel + 1;
        end else if (ps_run != 0) begin
            if (ps_run != 2) n_ps_badlen <= n_ps_badlen + 1;
            ps_run <= 0;
        end
        if (bus.o_done) n_done <= n_done + 1;
        if (bus.o_err) n_err <= n_err + 1;
        if (bus.o_done && bus.o_err) n_both <= n_both + 1;
        if (o_areset) ars_run <= ars_run + 1;
        else if (ars_run != 0) begin
            n_ars <= n_ars + 1;
            ars_len_last <= ars_run;
            ars_run <= 0;
        end
    end

    int tests = 0, fails = 0;
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] sel, input logic updn, input logic [7:0] n);
        bus.i_req = 1'b1; bus.i_sel = sel; bus.i_updn = updn; bus.i_nsteps = n;
        @(negedge clk);
        bus.i_req = 1'b0;
    endtask

    typedef struct {
        logic       req;
        logic [2:0] sel;
        logic [7:0] nsteps;
        logic       e_done;
        logic       e_err;
    } vec_t;
    vec_t vecs[6];

    int s_ps, s_done, s_err, s_ars, s_bad, k, hit;

    initial begin
        rst_n = 1'b0; i_locked = 1'b1; pd_stuck = 1'b0; exp_pcs = 4'd0; exp_updn = 1'b0;
        bus.i_req = 1'b0; bus.i_sel = '0; bus.i_updn = 1'b0; bus.i_nsteps = '0;
        vecs[0] = '{1'b1, 3'd5, 8'd3, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 3'd7, 8'd1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 3'd0, 8'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 3'd4, 8'd0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 3'd1, 8'd4, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 3'd6, 8'd0, 1'b0, 1'b1};

        // Reset state, then release with the PLL already locked.
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.o_busy, 1);
        chk("rst_locked", o_locked, 0);
        chk("rst_done_err", {bus.o_done, bus.o_err}, 0);
        chk("rst_pll_pins", {o_pcs, o_phasestep, o_phaseupdown, o_areset}, 0);
        rst_n = 1'b1;
        @(negedge clk); chk("rel_busy_c1", bus.o_busy, 1);
        @(negedge clk); chk("rel_busy_c2", bus.o_busy, 1);
        @(negedge clk); chk("rel_busy_c3", bus.o_busy, 0);
        chk("rel_locked", o_locked, 1);
        chk("rel_no_pll_activity", n_ps + n_ars, 0);

        // Single-cycle IDLE outcomes: bad select, zero steps, no request.
        s_ps = n_ps;
        for (int i = 0; i < 6; i++) begin
            bus.i_req = vecs[i].req; bus.i_sel = vecs[i].sel; bus.i_nsteps = vecs[i].nsteps;
            @(negedge clk);
            bus.i_req = 1'b0;
            chk($sformatf("vec%0d_done", i), bus.o_done, vecs[i].e_done);
            chk($sformatf("vec%0d_err", i), bus.o_err, vecs[i].e_err);
            chk($sformatf("vec%0d_busy", i), bus.o_busy, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse1", i), {bus.o_done, bus.o_err}, 0);
        end
        chk("vec_no_steps", n_ps - s_ps, 0);

        // Three up-steps on C2.
        s_ps = n_ps; s_done = n_done; s_err = n_err; s_bad = n_ps_badlen + n_ps_badsel;
        exp_pcs = 4'd4; exp_updn = 1'b1;
        issue(3'd2, 1'b1, 8'd3);
        chk("op_busy_n1", bus.o_busy, 1);
        chk("op_step_n1", o_phasestep, 1);
        @(negedge clk); chk("op_step_n2", o_phasestep, 1);
        @(negedge clk); chk("op_step_n3", o_phasestep, 0);
        issue(3'd7, 1'b0, 8'd1);  // ignored while busy
        chk("busy_req_no_err", bus.o_err, 0);
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (bus.o_done) hit = 1;
        end
        chk("op_done_seen", hit, 1);
        chk("op_busy_at_done", bus.o_busy, 0);
        repeat (2) @(negedge clk);
        chk("op_step_pulses", n_ps - s_ps, 3);
        chk("op_step_shape_sel", n_ps_badlen + n_ps_badsel - s_bad, 0);
        chk("op_done_count", n_done - s_done, 1);
        chk("op_err_count", n_err - s_err, 0);
        chk("op_pcs_idle", o_pcs, 0);

        // phasedone never drops: handshake timeout, reset pulse, relock.
        pd_stuck = 1'b1; exp_pcs = 4'd3; exp_updn = 1'b0;
        s_done = n_done; s_ars = n_ars;
        issue(3'd1, 1'b0, 8'd2);
        k = 0;
        for (int i = 2; i < 100 && k == 0; i++) begin
            @(negedge clk);
            if (bus.o_err) k = i;
        end
        chk("to_err_cycle", k, PD_TIMEOUT + 3);
        chk("to_areset_at_err", o_areset, 1);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (!bus.o_busy) hit = 1;
        end
        chk("to_back_idle", hit, 1);
        repeat (2) @(negedge clk);
        chk("to_areset_len", ars_len_last, RST_CYCLES);
        chk("to_areset_count", n_ars - s_ars, 1);
        chk("to_locked", o_locked, 1);
        chk("to_no_done", n_done - s_done, 0);
        pd_stuck = 1'b0;

        // Lock loss during step 2 of 5, held past the relock timeout.
        s_ps = n_ps; s_done = n_done; s_err = n_err; s_ars = n_ars; s_bad = n_ps_badlen + n_ps_badsel;
        exp_pcs = 4'd5; exp_updn = 1'b0;
        issue(3'd3, 1'b0, 8'd5);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (n_ps - s_ps >= 2) hit = 1;
        end
        chk("ll_reached_step2", hit, 1);
        i_locked = 1'b0;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (bus.o_err) hit = 1;
        end
        chk("ll_err_seen", hit, 1);
        chk("ll_locked_low", o_locked, 0);
        hit = 0;
        for (int i = 0; i < 600 && !hit; i++) begin
            @(negedge clk);
            if (n_ars - s_ars >= 2) hit = 1;
        end
        chk("ll_second_areset", hit, 1);
        chk("ll_areset_len", ars_len_last, RST_CYCLES);
        i_locked = 1'b1;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (!bus.o_busy) hit = 1;
        end
        chk("ll_back_idle", hit, 1);
        repeat (2) @(negedge clk);
        chk("ll_locked", o_locked, 1);
        chk("ll_no_done", n_done - s_done, 0);
        chk("ll_err_count", n_err - s_err, 1);
        chk("ll_steps_aborted", n_ps - s_ps, 2);
        chk("ll_step_shape_sel", n_ps_badlen + n_ps_badsel - s_bad, 0);
        chk("never_done_and_err", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
